// File: rtl/aer_pkg.sv
// Shared AER definitions: event type codes, collector FSM states and address-field slicing.
package aer_pkg;

    typedef enum logic [1:0] {
        EV_SPIKE      = 2'b00,
        EV_TS_END     = 2'b01,
        EV_SAMPLE_END = 2'b10,
        EV_RSVD       = 2'b11
    } ev_type_e;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        UPDATE,
        ACK,
        CLR
    } state_e;

    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned w);
        return (addr >> lsb) & ((32'd1 << w) - 32'd1);
    endfunction

    // The type code always occupies the top two bits of an aw-bit address.
    function automatic ev_type_e addr_type(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] t;
        t = addr >> (aw - 2);
        return ev_type_e'(t[1:0]);
    endfunction

endpackage

// File: rtl/aer_spike_collector_if.sv
// AER output-arbiter link: 4-phase REQ/ACK handshake with the event address.
interface aer_spike_collector_if #(
    parameter int AW = 11
);
    logic          AEROUT_REQ;
    logic [AW-1:0] AEROUT_ADDR;
    logic          AEROUT_ACK;

    modport master (output AEROUT_REQ, AEROUT_ADDR, input AEROUT_ACK);
    modport slave  (input AEROUT_REQ, AEROUT_ADDR, output AEROUT_ACK);
endinterface

// File: rtl/spike_cnt_ram.sv
// Spike counter storage: one synchronous write port, one synchronous read-before-write read port.
module spike_cnt_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/aer_spike_collector.sv
// AER spike collector: per-neuron saturating counters, time-step tracking and running argmax.
// Define AER_REQ_SYNC_EN to pass AEROUT_REQ through a 2-flop synchronizer.
module aer_spike_collector
    import aer_pkg::*;
#(
    parameter  int CORE_W    = 8,
    parameter  int CORE_H    = 8,
    parameter  int CORE_C    = 8,
    parameter  int TIME_STEP = 8,
    parameter  int CNT_WIDTH = 8,
    localparam int CW        = $clog2(CORE_C),
    localparam int HW        = $clog2(CORE_H),
    localparam int WW        = $clog2(CORE_W),
    localparam int AW        = 2 + CW + HW + WW,
    localparam int N         = CORE_W * CORE_H * CORE_C,
    localparam int NW        = $clog2(N),
    localparam int TSW       = $clog2(TIME_STEP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aer_spike_collector_if.slave aer,
    input  logic                 CLEAR,
    output logic                 CLEAR_BUSY,
    input  logic                 RD_EN,
    input  logic [NW-1:0]        RD_ADDR,
    output logic [CNT_WIDTH-1:0] RD_DATA,
    output logic                 RD_VALID,
    output logic [TSW-1:0]       TS_CNT,
    output logic                 SAMPLE_DONE,
    output logic [NW-1:0]        WIN_IDX,
    output logic [CNT_WIDTH-1:0] WIN_CNT
);
    localparam logic [TSW-1:0] TS_LAST = TSW'(TIME_STEP - 1);

    function automatic logic [NW-1:0] addr_to_idx(input logic [AW-1:0] a);
        logic [31:0] a32, y, x, c;
        a32 = 32'(a);
        c   = addr_field(a32, 0, CW);
        x   = addr_field(a32, CW, WW);
        y   = addr_field(a32, CW + WW, HW);
        return NW'((y * CORE_W + x) * CORE_C + c);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_e               state, state_nx;
    logic                 req_in;
    logic                 ack_q, clr_pend, rd_vld_p1;
    logic [NW-1:0]        clr_idx;
    logic                 clr_last, go_clr, cap_ok;
    ev_type_e             cap_type, ev_type_p1;
    logic [NW-1:0]        cap_idx, ev_idx_p1;
    logic [CNT_WIDTH-1:0] ram_rdata, cnt_new, ram_wdata;
    logic                 ram_we, ram_re;
    logic [NW-1:0]        ram_waddr, ram_raddr;

`ifdef AER_REQ_SYNC_EN
    logic req_s1, req_s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
        end else begin
            req_s1 <= aer.AEROUT_REQ;
            req_s2 <= req_s1;
        end
    end
    assign req_in = req_s2;
`else
    assign req_in = aer.AEROUT_REQ;
`endif

    assign cap_idx  = addr_to_idx(aer.AEROUT_ADDR);
    assign cap_type = addr_type(32'(aer.AEROUT_ADDR), AW);
    assign cnt_new  = sat_inc(ram_rdata);
    assign clr_last = (clr_idx == NW'(N - 1));
    assign go_clr   = clr_pend | CLEAR;
    // The RMW read shares the RAM read port; readback always wins, so CAPTURE waits on a conflict.
    assign cap_ok   = !RD_EN || (RD_ADDR == cap_idx);

    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_waddr = ev_idx_p1;
        ram_wdata = cnt_new;
        ram_re    = RD_EN;
        ram_raddr = RD_EN ? RD_ADDR : cap_idx;
        case (state)
            IDLE: begin
                if (go_clr)      state_nx = CLR;
                else if (req_in) state_nx = CAPTURE;
            end
            CAPTURE: begin
                ram_re = 1'b1;
                if (cap_ok) state_nx = UPDATE;
            end
            UPDATE: begin
                ram_we   = (ev_type_p1 == EV_SPIKE);
                state_nx = ACK;
            end
            ACK: begin
                if (!req_in) state_nx = IDLE;
            end
            CLR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_idx;
                ram_wdata = '0;
                if (clr_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ack_q      <= 1'b0;
            CLEAR_BUSY <= 1'b0;
            clr_pend   <= 1'b0;
            clr_idx    <= '0;
            rd_vld_p1  <= 1'b0;
            TS_CNT     <= '0;
            WIN_IDX    <= '0;
            WIN_CNT    <= '0;
        end else begin
            state      <= state_nx;
            ack_q      <= (state_nx == ACK);
            CLEAR_BUSY <= (state_nx == CLR);
            clr_pend   <= (state == IDLE) ? 1'b0 : (clr_pend | CLEAR);
            rd_vld_p1  <= RD_EN;
            if (state == CLR) clr_idx <= clr_last ? '0 : clr_idx + NW'(1);
            if (state == IDLE && go_clr) begin
                TS_CNT  <= '0;
                WIN_IDX <= '0;
                WIN_CNT <= '0;
            end
            if (state == UPDATE) begin
                case (ev_type_p1)
                    EV_SPIKE: begin
                        // Strictly greater: a tie keeps the neuron that got there first.
                        if (cnt_new > WIN_CNT) begin
                            WIN_IDX <= ev_idx_p1;
                            WIN_CNT <= cnt_new;
                        end
                    end
                    EV_TS_END:     TS_CNT <= (TS_CNT == TS_LAST) ? '0 : TS_CNT + TSW'(1);
                    EV_SAMPLE_END: TS_CNT <= '0;
                    default: ;
                endcase
            end
        end
    end

    // CAPTURE -> UPDATE boundary: event fields held for the read-modify-write
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            ev_type_p1 <= cap_type;
            ev_idx_p1  <= cap_idx;
        end
    end

    assign aer.AEROUT_ACK = ack_q;
    assign SAMPLE_DONE    = (state == UPDATE) && (ev_type_p1 == EV_SAMPLE_END);
    assign RD_VALID       = rd_vld_p1;
    assign RD_DATA        = rd_vld_p1 ? ram_rdata : '0;

    spike_cnt_ram #(
        .DEPTH (N),
        .AW    (NW),
        .DW    (CNT_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_aer_spike_collector.sv
// Directed plus randomized bench for aer_spike_collector against a behavioural counter/argmax model.
module tb_aer_spike_collector;
    localparam int CORE_W = 8, CORE_H = 8, CORE_C = 8, TIME_STEP = 8, CNT_WIDTH = 8;
    localparam int N = 512, NW = 9, AW = 11, TSW = 3;
    localparam int CNT_MAX = 255;
`ifdef AER_REQ_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 CLEAR = 1'b0;
    logic                 CLEAR_BUSY;
    logic                 RD_EN = 1'b0;
    logic [NW-1:0]        RD_ADDR = '0;
    logic [CNT_WIDTH-1:0] RD_DATA;
    logic                 RD_VALID;
    logic [TSW-1:0]       TS_CNT;
    logic                 SAMPLE_DONE;
    logic [NW-1:0]        WIN_IDX;
    logic [CNT_WIDTH-1:0] WIN_CNT;

    aer_spike_collector_if #(.AW(AW)) aer_bus ();

    aer_spike_collector #(
        .CORE_W(CORE_W), .CORE_H(CORE_H), .CORE_C(CORE_C),
        .TIME_STEP(TIME_STEP), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .aer(aer_bus),
        .CLEAR(CLEAR), .CLEAR_BUSY(CLEAR_BUSY),
        .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .TS_CNT(TS_CNT), .SAMPLE_DONE(SAMPLE_DONE), .WIN_IDX(WIN_IDX), .WIN_CNT(WIN_CNT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int m_cnt[N];
    int m_ts, m_win_idx, m_win_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ts = 0; m_win_idx = 0; m_win_cnt = 0;
    endtask

    task automatic model_event(input int t, input int y, input int x, input int c);
        int idx;
        idx = ((y * CORE_W) + x) * CORE_C + c;
        case (t)
            0: begin
                if (m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
                if (m_cnt[idx] > m_win_cnt) begin
                    m_win_idx = idx;
                    m_win_cnt = m_cnt[idx];
                end
            end
            1: m_ts = (m_ts + 1) % TIME_STEP;
            2: m_ts = 0;
            default: ;
        endcase
    endtask

    task automatic send(input int t, input int y, input int x, input int c, input bit peek);
        int n, m, sd, idx, pre;
        idx = ((y * CORE_W) + x) * CORE_C + c;
        pre = m_cnt[idx];
        @(negedge clk);
        aer_bus.AEROUT_ADDR = AW'((t << 9) | (y << 6) | (x << 3) | c);
        aer_bus.AEROUT_REQ  = 1'b1;
        n = 0; sd = 0;
        while (aer_bus.AEROUT_ACK !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            sd += int'(SAMPLE_DONE);
            if (peek && n == LAT) begin
                RD_EN = 1'b0;
                chk("collide_valid", 32'(RD_VALID), 1);
                chk("collide_data", 32'(RD_DATA), pre);
            end
            if (peek && n == LAT - 1) begin
                RD_EN   = 1'b1;
                RD_ADDR = NW'(idx);
            end
        end
        RD_EN = 1'b0;
        chk("ack_latency", n, LAT);
        model_event(t, y, x, c);
        aer_bus.AEROUT_REQ = 1'b0;
        m = 0;
        while (aer_bus.AEROUT_ACK !== 1'b0 && m < 20) begin
            @(negedge clk);
            m++;
            sd += int'(SAMPLE_DONE);
        end
        chk("ack_release", 32'(aer_bus.AEROUT_ACK), 0);
        chk("sample_done_pulses", sd, (t == 2) ? 1 : 0);
        chk("ts_cnt", 32'(TS_CNT), m_ts);
        chk("win_idx", 32'(WIN_IDX), m_win_idx);
        chk("win_cnt", 32'(WIN_CNT), m_win_cnt);
    endtask

    task automatic send_idx(input int t, input int idx, input bit peek);
        send(t, idx / (CORE_W * CORE_C), (idx / CORE_C) % CORE_W, idx % CORE_C, peek);
    endtask

    task automatic rd_chk(input string tag, input int idx, input int exp);
        @(negedge clk);
        RD_EN   = 1'b1;
        RD_ADDR = NW'(idx);
        @(negedge clk);
        RD_EN = 1'b0;
        chk("rd_valid", 32'(RD_VALID), 1);
        chk(tag, 32'(RD_DATA), exp);
    endtask

    task automatic do_clear(output int cycles);
        @(negedge clk);
        CLEAR = 1'b1;
        @(negedge clk);
        CLEAR = 1'b0;
        cycles = 0;
        while (CLEAR_BUSY === 1'b1 && cycles < 2000) begin
            cycles++;
            @(negedge clk);
        end
        model_clear();
    endtask

    initial begin
        int cyc, b, n, early;
        int pool_y[6], pool_x[6], pool_c[6];

        aer_bus.AEROUT_REQ  = 1'b0;
        aer_bus.AEROUT_ADDR = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(aer_bus.AEROUT_ACK), 0);
        chk("rst_busy", 32'(CLEAR_BUSY), 0);
        chk("rst_rd_valid", 32'(RD_VALID), 0);
        chk("rst_rd_data", 32'(RD_DATA), 0);
        chk("rst_ts", 32'(TS_CNT), 0);
        chk("rst_sample_done", 32'(SAMPLE_DONE), 0);
        chk("rst_win_idx", 32'(WIN_IDX), 0);
        chk("rst_win_cnt", 32'(WIN_CNT), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_clear(cyc);
        chk("clear_busy_cycles", cyc, N);
        for (int i = 0; i < N; i++) rd_chk("clear_zero", i, 0);

        repeat (3) send(0, 2, 3, 5, 1'b0);
        rd_chk("idx157_count", 157, 3);
        chk("idx157_win_idx", 32'(WIN_IDX), 157);
        chk("idx157_win_cnt", 32'(WIN_CNT), 3);

        do_clear(cyc);
        chk("clear2_busy_cycles", cyc, N);
        send_idx(0, 4, 1'b0);
        send_idx(0, 9, 1'b0);
        send_idx(0, 4, 1'b0);
        send_idx(0, 9, 1'b0);
        chk("tie_win_idx", 32'(WIN_IDX), 4);
        chk("tie_win_cnt", 32'(WIN_CNT), 2);
        send_idx(0, 9, 1'b1);
        chk("tie_break_win_idx", 32'(WIN_IDX), 9);

        repeat (300) send_idx(0, 0, 1'b0);
        rd_chk("sat_idx0", 0, CNT_MAX);
        chk("sat_win_cnt", 32'(WIN_CNT), CNT_MAX);

        for (int i = 0; i < 8; i++) begin
            send(1, 0, 0, 0, 1'b0);
            chk("ts_step", 32'(TS_CNT), (i + 1) % 8);
        end
        send(1, 0, 0, 0, 1'b0);
        send(2, 0, 0, 0, 1'b0);
        chk("ts_after_sample", 32'(TS_CNT), 0);
        rd_chk("retained_idx0", 0, CNT_MAX);

        send(3, 2, 3, 5, 1'b0);
        rd_chk("reserved_no_change", 157, m_cnt[157]);

        @(negedge clk);
        CLEAR = 1'b1;
        @(negedge clk);
        CLEAR = 1'b0;
        aer_bus.AEROUT_ADDR = AW'((0 << 9) | (1 << 6) | (2 << 3) | 3);
        aer_bus.AEROUT_REQ  = 1'b1;
        model_clear();
        b = 0; early = 0;
        while (CLEAR_BUSY === 1'b1 && b < 2000) begin
            if (aer_bus.AEROUT_ACK !== 1'b0) early++;
            @(negedge clk);
            b++;
        end
        chk("req_during_clear_busy_cycles", b, N);
        chk("req_during_clear_no_ack", early, 0);
        n = 0;
        while (aer_bus.AEROUT_ACK !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_after_clear", n, 3);
        model_event(0, 1, 2, 3);
        aer_bus.AEROUT_REQ = 1'b0;
        n = 0;
        while (aer_bus.AEROUT_ACK !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_after_clear_release", 32'(aer_bus.AEROUT_ACK), 0);
        chk("after_clear_win_idx", 32'(WIN_IDX), 83);
        rd_chk("after_clear_idx83", 83, 1);

        for (int i = 0; i < 6; i++) begin
            pool_y[i] = $urandom_range(0, CORE_H - 1);
            pool_x[i] = $urandom_range(0, CORE_W - 1);
            pool_c[i] = $urandom_range(0, CORE_C - 1);
        end
        for (int e = 0; e < 60; e++) begin
            int r, p;
            r = $urandom_range(0, 19);
            p = $urandom_range(0, 5);
            if (r < 14)       send(0, pool_y[p], pool_x[p], pool_c[p], $urandom_range(0, 3) == 0);
            else if (r < 16)  send(1, pool_y[p], pool_x[p], pool_c[p], 1'b0);
            else if (r == 16) send(2, pool_y[p], pool_x[p], pool_c[p], 1'b0);
            else              send(3, pool_y[p], pool_x[p], pool_c[p], 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            int idx;
            idx = ((pool_y[i] * CORE_W) + pool_x[i]) * CORE_C + pool_c[i];
            rd_chk("random_readback", idx, m_cnt[idx]);
        end

        @(negedge clk);
        aer_bus.AEROUT_ADDR = AW'(5);
        aer_bus.AEROUT_REQ  = 1'b1;
        n = 0;
        while (aer_bus.AEROUT_ACK !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_ack_seen", 32'(aer_bus.AEROUT_ACK), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_ack_drop", 32'(aer_bus.AEROUT_ACK), 0);
        chk("midreset_win_cnt", 32'(WIN_CNT), 0);
        chk("midreset_ts", 32'(TS_CNT), 0);
        aer_bus.AEROUT_REQ = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ack", 32'(aer_bus.AEROUT_ACK), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/aer_spike_collector.md
AER_SPIKE_COLLECTOR -- requirements
Module: aer_spike_collector

Interface
REQ-001 SHALL have parameter CORE_W, default 8: core array width, x positions.
REQ-002 SHALL have parameter CORE_H, default 8: core array height, y positions.
REQ-003 SHALL have parameter CORE_C, default 8: output neurons per core.
REQ-004 SHALL have parameter TIME_STEP, default 8: time steps per sample.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: per-neuron spike counter width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port AEROUT_REQ, input, 1 bit: event request from the layer output arbiter.
REQ-009 SHALL have port AEROUT_ADDR, input, AW = 2+clog2(CORE_C)+clog2(CORE_H)+clog2(CORE_W) bits: event address {type[1:0], y, x, c}, type in MSBs.
REQ-010 SHALL have port AEROUT_ACK, output, 1 bit: 4-phase acknowledge.
REQ-011 SHALL have port CLEAR, input, 1 bit: pulse that starts a counter-clear sweep.
REQ-012 SHALL have port CLEAR_BUSY, output, 1 bit: high while the sweep runs.
REQ-013 SHALL have port RD_EN, input, 1 bit, and RD_ADDR, input, clog2(N) bits, with N=CORE_W*CORE_H*CORE_C: readback request.
REQ-014 SHALL have port RD_DATA, output, CNT_WIDTH bits, and RD_VALID, output, 1 bit: readback result.
REQ-015 SHALL have port TS_CNT, output, clog2(TIME_STEP) bits: current time step.
REQ-016 SHALL have port SAMPLE_DONE, output, 1 bit: one-cycle pulse at sample end.
REQ-017 SHALL have ports WIN_IDX, output, clog2(N) bits, and WIN_CNT, output, CNT_WIDTH bits: running argmax neuron and its count.

Function
REQ-018 Type encoding SHALL be: 2'b00 spike, 2'b01 time-step end, 2'b10 sample end, 2'b11 reserved.
REQ-019 Reserved-type events SHALL be acknowledged with no state change.
REQ-020 The FSM SHALL have states IDLE, CAPTURE, UPDATE, ACK and CLR.
REQ-021 In IDLE, REQ high with CLEAR_BUSY low SHALL go to CAPTURE, which latches AEROUT_ADDR.
REQ-022 CAPTURE SHALL go to UPDATE; UPDATE performs a read-modify-write, then goes to ACK.
REQ-023 In ACK, AEROUT_ACK SHALL be high until REQ is sampled low, then go to IDLE with ACK low.
REQ-024 The latency from REQ rise to ACK rise SHALL be 3 cycles, or 5 cycles when AER_REQ_SYNC_EN is defined.
REQ-025 A spike event SHALL increment counter index ((y*CORE_W)+x)*CORE_C+c, saturating at 2^CNT_WIDTH-1.
REQ-026 A time-step-end event SHALL increment TS_CNT, wrapping from TIME_STEP-1 to 0.
REQ-027 A sample-end event SHALL pulse SAMPLE_DONE in its UPDATE cycle and reset TS_CNT to 0; counters SHALL be retained.
REQ-028 Argmax SHALL update in UPDATE when the new count is strictly greater than WIN_CNT, so ties keep the earlier winner.
REQ-029 CLEAR SHALL only be accepted in IDLE; a CLEAR pulse outside IDLE SHALL be held pending until IDLE is reached.
REQ-030 CLR SHALL zero one counter per cycle (N cycles), zero WIN_IDX, WIN_CNT and TS_CNT, and hold CLEAR_BUSY high throughout.
REQ-031 A REQ arriving during CLR SHALL be left unacknowledged until CLR finishes.
REQ-032 RD_DATA and RD_VALID SHALL be registered one cycle after RD_EN, independent of FSM state.
REQ-033 A read that collides with an UPDATE write to the same index SHALL return the pre-update value.

Reset
REQ-034 On rst_n low, all outputs SHALL be 0, the FSM SHALL be in IDLE, and TS_CNT, WIN_IDX, WIN_CNT and any pending clear SHALL be 0.
REQ-035 Counter storage SHALL NOT be reset; software SHALL issue CLEAR after reset.
REQ-036 Reset asserted mid-handshake SHALL drop ACK immediately, and the event SHALL be lost.

Configuration
REQ-037 With AER_REQ_SYNC_EN defined, AEROUT_REQ SHALL pass through a 2-flop synchronizer, and ADDR SHALL be latched in CAPTURE after the synchronized edge.
REQ-038 Without AER_REQ_SYNC_EN, AEROUT_REQ SHALL be used directly as a same-clock signal.

Structure
REQ-039 Type codes, the FSM state enum and the address-field slicing helper SHALL live in package aer_pkg, shared with the arbiter and mapper.
REQ-040 Counter storage SHALL be a sub-module spike_cnt_ram with one synchronous write port and one synchronous read port, with the RMW read port muxed against the external readback port.

Verification
REQ-041 Reset, then CLEAR -> CLEAR_BUSY high for 512 cycles (N=512), then all RD_DATA = 0.
REQ-042 Spike {00, y=2, x=3, c=5} sent 3 times -> RD_ADDR=157 returns 3, WIN_IDX=157, WIN_CNT=3, ACK latency 3 cycles.
REQ-043 300 spikes to index 0 with CNT_WIDTH=8 -> count 255, no wrap.
REQ-044 8 type-01 events -> TS_CNT 1..7 then 0; a type-10 event -> SAMPLE_DONE pulses for 1 cycle and TS_CNT = 0.
REQ-045 Index 4 and index 9 each reach 2 spikes, index 4 first -> WIN_IDX stays 4.
REQ-046 REQ held during a CLEAR sweep -> ACK only after CLEAR_BUSY falls; with AER_REQ_SYNC_EN defined, ACK latency is 5 cycles.
